// File: rtl/alu_cmd_issue.sv
// Issue stage for the combinational ALU: queues commands, feeds one at a time into
// registered ALU operands, and captures the result behind a valid/ready handshake.
module alu_cmd_issue #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_cin,
  input  logic [3:0]   cmd_mode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [3:0]   alu_mode,
  input  logic [N-1:0] alu_y,
  input  logic         alu_cout,
  input  logic         alu_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_y,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         ovf_sticky,
  input  logic         ovf_clr,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * N + 5;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_q, state_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wrPtr_q, rdPtr_q;
  logic [AW:0]    count_q, count_d;
  logic [EW-1:0]  headEntry;
  logic           fifoEmpty, fifoFull, push, pop, capture, release_;
  logic           arithMode, maskedCout, maskedOvf;

  logic [N-1:0]   aluA_q, aluB_q, resY_q;
  logic           aluCin_q, resValid_q, resCout_q, resOvf_q, ovfSticky_q;
  logic [3:0]     aluMode_q;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == (AW + 1)'(DEPTH));
  assign push      = cmd_valid && !fifoFull;
  assign headEntry = mem_q[rdPtr_q];

  // Only add and subtract produce meaningful carry/overflow
  assign arithMode  = (aluMode_q == 4'd4) || (aluMode_q == 4'd5);
  assign maskedCout = arithMode && alu_cout;
  assign maskedOvf  = arithMode && alu_ovf;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    release_ = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          release_ = 1'b1;
          if (!fifoEmpty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {cmd_mode, cmd_cin, cmd_b, cmd_a};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluCin_q    <= 1'b0;
      aluMode_q   <= 4'd0;
      resValid_q  <= 1'b0;
      resY_q      <= '0;
      resCout_q   <= 1'b0;
      resOvf_q    <= 1'b0;
      ovfSticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) begin
        rdPtr_q   <= rdPtr_q + 1'b1;
        aluA_q    <= headEntry[N-1:0];
        aluB_q    <= headEntry[2*N-1:N];
        aluCin_q  <= headEntry[2*N];
        aluMode_q <= headEntry[EW-1:2*N+1];
      end
      if (capture) begin
        resValid_q <= 1'b1;
        resY_q     <= alu_y;
        resCout_q  <= maskedCout;
        resOvf_q   <= maskedOvf;
      end else if (release_) begin
        resValid_q <= 1'b0;
      end
      // A new overflow takes priority over a simultaneous clear
      if (capture && maskedOvf) ovfSticky_q <= 1'b1;
      else if (ovf_clr)         ovfSticky_q <= 1'b0;
    end
  end

  assign cmd_ready  = !fifoFull;
  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_cin    = aluCin_q;
  assign alu_mode   = aluMode_q;
  assign res_valid  = resValid_q;
  assign res_y      = resY_q;
  assign res_cout   = resCout_q;
  assign res_ovf    = resOvf_q;
  assign ovf_sticky = ovfSticky_q;
  assign busy       = (state_q != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a small behavioural ALU closing the loop.
module tb_alu_cmd_issue;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_cin, alu_cin, alu_cout, alu_ovf;
  logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y;
  logic [3:0]  cmd_mode, alu_mode;
  logic        res_valid, res_ready, res_cout, res_ovf, ovf_sticky, ovf_clr, busy;
  int          testsRun = 0;
  int          testsFailed = 0;

  alu_cmd_issue #(.N(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_mode(cmd_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_cout(res_cout), .res_ovf(res_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Logic modes deliberately report carry/overflow so masking is exercised
  logic [16:0] sum;
  always_comb begin
    sum      = 17'd0;
    alu_y    = 16'h0000;
    alu_cout = 1'b1;
    alu_ovf  = 1'b1;
    case (alu_mode)
      4'd4: begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
        alu_y    = sum[15:0];
        alu_cout = sum[16];
        alu_ovf  = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      end
      4'd5: begin
        sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_y    = sum[15:0];
        alu_cout = sum[16];
        alu_ovf  = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
      end
      4'd6:    alu_y = alu_a & alu_b;
      4'd7:    alu_y = alu_a | alu_b;
      4'd9:    alu_y = alu_a ^ alu_b;
      4'd11:   alu_y = ~alu_a;
      4'd14:   alu_y = alu_a;
      default: alu_y = alu_a ^ ~alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] mode);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = 1'b0;
    cmd_mode  = mode;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    testsRun++; if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    testsRun++; if (alu_a !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_alu_a: got %h expected 0000", alu_a); end
    testsRun++; if (alu_mode !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_alu_mode: got %0d expected 0", alu_mode); end
    testsRun++; if (ovf_sticky !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sticky: got %b expected 0", ovf_sticky); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_latency();
    setCmd(16'h7FFF, 16'h0001, 4'd4);
    tick();
    cmd_valid = 1'b0;
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL add_valid_t0: got %b expected 0", res_valid); end
    tick();
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL add_valid_t1: got %b expected 0", res_valid); end
    testsRun++; if (alu_a !== 16'h7FFF) begin testsFailed++; $display("[TB] FAIL add_alu_a: got %h expected 7fff", alu_a); end
    tick();
    testsRun++; if (res_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL add_valid_t2: got %b expected 1", res_valid); end
    testsRun++; if (res_y !== 16'h8000) begin testsFailed++; $display("[TB] FAIL add_res_y: got %h expected 8000", res_y); end
    testsRun++; if (res_ovf !== 1'b1) begin testsFailed++; $display("[TB] FAIL add_res_ovf: got %b expected 1", res_ovf); end
    testsRun++; if (res_cout !== 1'b0) begin testsFailed++; $display("[TB] FAIL add_res_cout: got %b expected 0", res_cout); end
    testsRun++; if (ovf_sticky !== 1'b1) begin testsFailed++; $display("[TB] FAIL add_sticky: got %b expected 1", ovf_sticky); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL add_release: got %b expected 0", res_valid); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL add_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fill_order();
    logic [15:0] aVec [5] = '{16'hF0F0, 16'h1200, 16'hFFFF, 16'h00FF, 16'hABCD};
    logic [15:0] bVec [5] = '{16'hFF00, 16'h0034, 16'h0F0F, 16'h0000, 16'h0000};
    logic [3:0]  mVec [5] = '{4'd6, 4'd7, 4'd9, 4'd11, 4'd14};
    logic [15:0] expY [5] = '{16'hF000, 16'h1234, 16'hF0F0, 16'hFF00, 16'hABCD};
    int waitCnt;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setCmd(aVec[i], bVec[i], mVec[i]);
      testsRun++; if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL fill_ready_%0d: got %b expected 1", i, cmd_ready); end
      tick();
    end
    testsRun++; if (cmd_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_full: got %b expected 0", cmd_ready); end
    setCmd(16'hDEAD, 16'h0000, 4'd14);
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitCnt = 0;
      while (res_valid !== 1'b1 && waitCnt < 10) begin
        tick();
        waitCnt++;
      end
      testsRun++; if (res_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL fill_timeout_%0d: got valid %b expected 1", i, res_valid); end
      testsRun++; if (res_y !== expY[i]) begin testsFailed++; $display("[TB] FAIL fill_order_%0d: got %h expected %h", i, res_y, expY[i]); end
      testsRun++; if ({res_cout, res_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL fill_mask_%0d: got %b expected 00", i, {res_cout, res_ovf}); end
      tick();
    end
    repeat (4) tick();
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_extra: got %b expected 0", res_valid); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    setCmd(16'h0005, 16'h0003, 4'd5);
    tick();
    setCmd(16'h0000, 16'h0001, 4'd5);
    tick();
    setCmd(16'h8000, 16'h0001, 4'd5);
    tick();
    cmd_valid = 1'b0;
    testsRun++; if (res_valid !== 1'b1 || res_y !== 16'h0002) begin testsFailed++; $display("[TB] FAIL b2b_r0: got v=%b y=%h expected v=1 y=0002", res_valid, res_y); end
    testsRun++; if ({res_cout, res_ovf} !== 2'b10) begin testsFailed++; $display("[TB] FAIL b2b_r0_flags: got %b expected 10", {res_cout, res_ovf}); end
    tick();
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_gap0: got %b expected 0", res_valid); end
    tick();
    testsRun++; if (res_valid !== 1'b1 || res_y !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL b2b_r1: got v=%b y=%h expected v=1 y=ffff", res_valid, res_y); end
    testsRun++; if ({res_cout, res_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL b2b_r1_flags: got %b expected 00", {res_cout, res_ovf}); end
    tick();
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_gap1: got %b expected 0", res_valid); end
    tick();
    testsRun++; if (res_valid !== 1'b1 || res_y !== 16'h7FFF) begin testsFailed++; $display("[TB] FAIL b2b_r2: got v=%b y=%h expected v=1 y=7fff", res_valid, res_y); end
    testsRun++; if ({res_cout, res_ovf} !== 2'b11) begin testsFailed++; $display("[TB] FAIL b2b_r2_flags: got %b expected 11", {res_cout, res_ovf}); end
    tick();
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_busy: got %b expected 0", busy); end
  endtask

  task automatic test_masking();
    res_ready = 1'b1;
    ovf_clr   = 1'b1;
    tick();
    testsRun++; if (ovf_sticky !== 1'b0) begin testsFailed++; $display("[TB] FAIL mask_clear0: got %b expected 0", ovf_sticky); end
    setCmd(16'h7FFF, 16'h0001, 4'd4);
    tick();
    setCmd(16'hF0F0, 16'h0FF0, 4'd6);
    tick();
    cmd_valid = 1'b0;
    tick();
    testsRun++; if (res_valid !== 1'b1 || res_ovf !== 1'b1) begin testsFailed++; $display("[TB] FAIL mask_add: got v=%b ovf=%b expected 1 1", res_valid, res_ovf); end
    testsRun++; if (ovf_sticky !== 1'b1) begin testsFailed++; $display("[TB] FAIL mask_set_wins: got %b expected 1", ovf_sticky); end
    ovf_clr = 1'b0;
    repeat (2) tick();
    testsRun++; if (res_valid !== 1'b1 || res_y !== 16'h00F0) begin testsFailed++; $display("[TB] FAIL mask_and_y: got v=%b y=%h expected v=1 y=00f0", res_valid, res_y); end
    testsRun++; if ({res_cout, res_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL mask_and_flags: got %b expected 00", {res_cout, res_ovf}); end
    repeat (4) tick();
    testsRun++; if (ovf_sticky !== 1'b1) begin testsFailed++; $display("[TB] FAIL mask_sticky_hold: got %b expected 1", ovf_sticky); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    testsRun++; if (ovf_sticky !== 1'b0) begin testsFailed++; $display("[TB] FAIL mask_sticky_clr: got %b expected 0", ovf_sticky); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setCmd(16'h0100 + 16'(i), 16'h0001, 4'd4);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_busy_pre: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    testsRun++; if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_res_valid: got %b expected 0", res_valid); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    testsRun++; if (cmd_ready !== 1'b1 || alu_a !== 16'h0000) begin testsFailed++; $display("[TB] FAIL mid_regs: got ready=%b a=%h expected 1 0000", cmd_ready, alu_a); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      testsRun++; if (res_valid !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_quiet_%0d: got v=%b busy=%b expected 0 0", i, res_valid, busy); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 16'h0000;
    cmd_b     = 16'h0000;
    cmd_cin   = 1'b0;
    cmd_mode  = 4'd0;
    res_ready = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_add_latency();
    test_fill_order();
    test_back_to_back();
    test_masking();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
